mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage pipeline. Consumes the EX/MEM register outputs and drives a request/acknowledge data-memory port.
- Stalls the upstream pipeline while a load or store is outstanding.
- Contains the MEM/WB pipeline register, which feeds writeback.
- Flags misaligned accesses and memory timeouts.

Parameters:
TIMEOUT_CYCLES, 16, maximum WAIT cycles without ack before abort; 0 disables the timeout

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
RegWrite_i  input  1  from EX/MEM
MemtoReg_i  input  1  from EX/MEM
MemRead_i  input  1  from EX/MEM: load
MemWrite_i  input  1  from EX/MEM: store
ALUResult_i  input  32  from EX/MEM: effective address or ALU result
RS2data_i  input  32  from EX/MEM: store data
RDaddr_i  input  5  from EX/MEM: destination register
mem_req_o  output  1  memory request, held high until ack or abort
mem_we_o  output  1  1 = write
mem_addr_o  output  32  word address (byte address, bits [1:0] = 0)
mem_wdata_o  output  32  write data
mem_ack_i  input  1  one-cycle completion strobe
mem_rdata_i  input  32  read data, valid when mem_ack_i = 1
stall_o  output  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
err_o  output  1  one-cycle pulse: misaligned access or timeout
RegWrite_o  output  1  MEM/WB
MemtoReg_o  output  1  MEM/WB
ALUResult_o  output  32  MEM/WB
ReadData_o  output  32  MEM/WB load data
RDaddr_o  output  5  MEM/WB

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i; all state updates on the posedge of clk_i.
- Reset: state IDLE, timeout counter 0. All outputs 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o, and all MEM/WB fields.
- stall_o is combinational from the current state and inputs. Every other output is registered.
- Definitions: access = MemRead_i | MemWrite_i; aligned = (ALUResult_i[1:0] == 0). If both MemRead_i and MemWrite_i are set, treat the access as a write.

FSM states: IDLE, WAIT.

IDLE:
- No access: no stall. MEM/WB captures the inputs; ReadData_o <= 0.
- Access and aligned:
  - stall_o = 1 this cycle.
  - Latch mem_addr_o = ALUResult_i, mem_wdata_o = RS2data_i, mem_we_o = MemWrite_i.
  - mem_req_o <= 1; go to WAIT; counter <= 0.
  - MEM/WB captures a bubble: RegWrite_o = 0, MemtoReg_o = 0, other fields don't-care and driven 0.
- Access and misaligned:
  - No request, no stall.
  - err_o <= 1 next cycle.
  - MEM/WB captures RDaddr/ALUResult with RegWrite_o = 0 and MemtoReg_o = 0 (instruction squashed).
- mem_ack_i in IDLE is ignored.

WAIT:
- mem_addr_o, mem_wdata_o and mem_we_o hold stable throughout.
- mem_ack_i = 1:
  - stall_o = 0.
  - MEM/WB captures the EX/MEM inputs. ReadData_o <= mem_rdata_i if load, else 0.
  - mem_req_o <= 0; go to IDLE.
  - Upstream advances at the same edge.
- No ack and TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1:
  - stall_o = 0; mem_req_o <= 0; err_o <= 1; go to IDLE.
  - MEM/WB captures a bubble (instruction dropped).
- Otherwise: stall_o = 1; counter increments; MEM/WB captures a bubble.
- Ack and timeout in the same cycle: ack wins, no error.

Latency and timing:
- Minimum access latency: request cycle plus ack cycle, i.e. 2 cycles of MEM occupancy and 1 stall cycle.
- Back-to-back accesses: a new request is issued the cycle after the ack, with no idle gap beyond the IDLE decode cycle.
- err_o is high for exactly one cycle per event.

Reset mid-WAIT: back to IDLE and mem_req_o = 0 after the edge. A late ack is then ignored.

Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1 bit.

Test Plan:
- Load, addr 0x100, mem_rdata 0xDEADBEEF, ack 3 cycles after request:
  - stall_o high 3 cycles, mem_req_o high 3 cycles.
  - Then RegWrite_o=1, MemtoReg_o=1, ReadData_o=0xDEADBEEF, RDaddr_o=5.
  - Bubbles during the stall.
- Store, addr 0x40, RS2data 0x12345678, ack the cycle after request:
  - mem_we_o=1, mem_addr_o=0x40, mem_wdata_o=0x12345678.
  - stall_o high 1 cycle; RegWrite_o=0.
- Misaligned load, addr 0x102:
  - mem_req_o stays 0, stall_o stays 0.
  - err_o pulses 1 cycle; RegWrite_o=0.
- Load with no ack, TIMEOUT_CYCLES=4:
  - mem_req_o high 4 cycles, then drops; err_o pulses once.
  - stall_o released on the 4th cycle; MEM/WB holds a bubble.
- Ack on the exact timeout cycle: normal completion, err_o=0, ReadData_o = rdata.
- rst_i asserted during WAIT:
  - Next cycle all outputs 0, state IDLE.
  - Ack arriving 1 cycle later has no effect.
  - The following ALU op (RegWrite_i=1, ALUResult_i=7) passes through with no stall.

Source files
------------

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// MEM stage of the 5-stage pipeline. Takes the EX/MEM register outputs, runs
// loads and stores over a request/acknowledge data-memory port, stalls the
// upstream pipeline while an access is outstanding, and holds the MEM/WB
// pipeline register that feeds writeback. Misaligned accesses and memory
// timeouts are reported on err_o as one-cycle pulses.
//
// Parameters
//   TIMEOUT_CYCLES : max WAIT cycles without ack before the access is
//                    aborted; 0 disables the timeout.
//
// Ports
//   clk_i, rst_i        : clock, synchronous active-high reset
//   RegWrite_i ..
//   RDaddr_i            : EX/MEM register fields
//   mem_req_o           : request, held high until ack or abort
//   mem_we_o            : 1 = write
//   mem_addr_o          : word-aligned byte address
//   mem_wdata_o         : write data
//   mem_ack_i           : one-cycle completion strobe
//   mem_rdata_i         : read data, valid with mem_ack_i
//   stall_o             : combinational; freezes PC, IF/ID, ID/EX, EX/MEM
//   err_o               : one-cycle pulse on misalignment or timeout
//   RegWrite_o ..
//   RDaddr_o            : MEM/WB register fields
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] ALUResult_i,
    input  logic [31:0] RS2data_i,
    input  logic [4:0]  RDaddr_i,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,

    output logic        stall_o,
    output logic        err_o,

    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic [31:0] ALUResult_o,
    output logic [31:0] ReadData_o,
    output logic [4:0]  RDaddr_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int LAST_INT = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_INT);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]       state_q,       state_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic             mem_req_q,     mem_req_d;
    logic             mem_we_q,      mem_we_d;
    logic [31:0]      mem_addr_q,    mem_addr_d;
    logic [31:0]      mem_wdata_q,   mem_wdata_d;
    logic             err_q,         err_d;
    logic             regwrite_q,    regwrite_d;
    logic             memtoreg_q,    memtoreg_d;
    logic [31:0]      aluresult_q,   aluresult_d;
    logic [31:0]      readdata_q,    readdata_d;
    logic [4:0]       rdaddr_q,      rdaddr_d;

    logic access;
    logic aligned;
    logic is_load;
    logic timeout_hit;

    assign access  = MemRead_i | MemWrite_i;
    assign aligned = (ALUResult_i[1:0] == 2'b00);
    // Read+write together is treated as a write, so only a pure read loads.
    assign is_load = MemRead_i & ~MemWrite_i;
    assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = 1'b0;
        // Address/data/direction hold their last values unless a new
        // request is launched; they stay stable through WAIT.
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = 1'b0;
        // Default MEM/WB content is a bubble.
        regwrite_d  = 1'b0;
        memtoreg_d  = 1'b0;
        aluresult_d = 32'd0;
        readdata_d  = 32'd0;
        rdaddr_d    = 5'd0;
        stall_o     = 1'b0;

        if (state_q == ST_IDLE) begin
            if (access && aligned) begin
                stall_o     = 1'b1;
                mem_req_d   = 1'b1;
                mem_we_d    = MemWrite_i;
                mem_addr_d  = ALUResult_i;
                mem_wdata_d = RS2data_i;
                cnt_d       = '0;
                state_d     = ST_WAIT;
            end else if (access) begin
                // Misaligned: squash the instruction but keep its identity
                // visible in MEM/WB for debug.
                err_d       = 1'b1;
                aluresult_d = ALUResult_i;
                rdaddr_d    = RDaddr_i;
            end else begin
                regwrite_d  = RegWrite_i;
                memtoreg_d  = MemtoReg_i;
                aluresult_d = ALUResult_i;
                rdaddr_d    = RDaddr_i;
            end
        end else begin
            if (mem_ack_i) begin
                // Ack has priority over a coincident timeout.
                regwrite_d  = RegWrite_i;
                memtoreg_d  = MemtoReg_i;
                aluresult_d = ALUResult_i;
                rdaddr_d    = RDaddr_i;
                readdata_d  = is_load ? mem_rdata_i : 32'd0;
                state_d     = ST_IDLE;
            end else if (timeout_hit) begin
                // Abort: drop the instruction and release the pipeline.
                err_d       = 1'b1;
                state_d     = ST_IDLE;
            end else begin
                stall_o     = 1'b1;
                mem_req_d   = 1'b1;
                cnt_d       = TIMEOUT_EN ? (cnt_q + CNT_W'(1)) : cnt_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            err_q       <= 1'b0;
            regwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
            aluresult_q <= 32'd0;
            readdata_q  <= 32'd0;
            rdaddr_q    <= 5'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
            regwrite_q  <= regwrite_d;
            memtoreg_q  <= memtoreg_d;
            aluresult_q <= aluresult_d;
            readdata_q  <= readdata_d;
            rdaddr_q    <= rdaddr_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign err_o       = err_q;
    assign RegWrite_o  = regwrite_q;
    assign MemtoReg_o  = memtoreg_q;
    assign ALUResult_o = aluresult_q;
    assign ReadData_o  = readdata_q;
    assign RDaddr_o    = rdaddr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//
// Cycle-vector bench for mem_access_stage with TIMEOUT_CYCLES = 4. Each table
// row holds the inputs for one cycle, the expected combinational stall for
// that cycle, and the expected registered outputs after the following edge.
// A hand-written sequence then measures a full timeout by counting cycles.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
    logic [31:0] ALUResult_i, RS2data_i;
    logic [4:0]  RDaddr_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o, err_o;
    logic        RegWrite_o, MemtoReg_o;
    logic [31:0] ALUResult_o, ReadData_o;
    logic [4:0]  RDaddr_o;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .RegWrite_i  (RegWrite_i),
        .MemtoReg_i  (MemtoReg_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .ALUResult_i (ALUResult_i),
        .RS2data_i   (RS2data_i),
        .RDaddr_i    (RDaddr_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_o     (stall_o),
        .err_o       (err_o),
        .RegWrite_o  (RegWrite_o),
        .MemtoReg_o  (MemtoReg_o),
        .ALUResult_o (ALUResult_o),
        .ReadData_o  (ReadData_o),
        .RDaddr_o    (RDaddr_o)
    );

    typedef struct {
        logic        rst, rw, m2r, mr, mw, ack;
        logic [31:0] alu, rs2, rdata;
        logic [4:0]  rd;
        logic        cs, es;          // check stall, expected stall
        logic        er, ee;          // expected req, err
        logic        cp, ew;          // check port fields, expected we
        logic [31:0] ea, ewd;         // expected addr, wdata
        logic        erw, em2r;
        logic [31:0] ealu;
        logic        crd;             // check ReadData
        logic [31:0] erdata;
        logic [4:0]  erd;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
    endtask

    task automatic add(
        input logic [31:0] rst, rw, m2r, mr, mw, alu, rs2, rd, ack, rdata,
        input logic [31:0] cs, es, er, ee, cp, ew, ea, ewd, erw, em2r, ealu, crd, erdata, erd);
        vec_t v;
        v.rst = rst[0]; v.rw = rw[0]; v.m2r = m2r[0]; v.mr = mr[0]; v.mw = mw[0];
        v.alu = alu; v.rs2 = rs2; v.rd = rd[4:0]; v.ack = ack[0]; v.rdata = rdata;
        v.cs = cs[0]; v.es = es[0]; v.er = er[0]; v.ee = ee[0]; v.cp = cp[0]; v.ew = ew[0];
        v.ea = ea; v.ewd = ewd; v.erw = erw[0]; v.em2r = em2r[0]; v.ealu = ealu;
        v.crd = crd[0]; v.erdata = erdata; v.erd = erd[4:0];
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        rst_i = v.rst; RegWrite_i = v.rw; MemtoReg_i = v.m2r; MemRead_i = v.mr;
        MemWrite_i = v.mw; ALUResult_i = v.alu; RS2data_i = v.rs2; RDaddr_i = v.rd;
        mem_ack_i = v.ack; mem_rdata_i = v.rdata;
    endtask

    task automatic nop();
        rst_i = 1'b0; RegWrite_i = 1'b0; MemtoReg_i = 1'b0; MemRead_i = 1'b0;
        MemWrite_i = 1'b0; ALUResult_i = 32'd0; RS2data_i = 32'd0; RDaddr_i = 5'd0;
        mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
    endtask

    initial begin
        vec_t v, e;
        int n_req, n_stall, n_err;
        bit released;

        //   rst rw m2r mr mw alu rs2 rd ack rdata | cs es er ee cp ew ea ewd erw em2r ealu crd erdata erd
        // reset
        add(1, 0,0,0,0, 0,0,0, 0,0,                      0,0, 0,0, 1,0,0,0, 0,0,0, 1,0,0);
        // plain ALU op passes through
        add(0, 1,0,0,0, 32'h11,0,3, 0,0,                 1,0, 0,0, 0,0,0,0, 1,0,32'h11, 1,0,3);
        // load 0x100, ack in the third request cycle
        add(0, 1,1,1,0, 32'h100,32'hAAAA5555,5, 0,0,     1,1, 1,0, 1,0,32'h100,32'hAAAA5555, 0,0,0, 1,0,0);
        add(0, 1,1,1,0, 32'h100,32'hAAAA5555,5, 0,0,     1,1, 1,0, 1,0,32'h100,32'hAAAA5555, 0,0,0, 1,0,0);
        add(0, 1,1,1,0, 32'h100,32'hAAAA5555,5, 0,0,     1,1, 1,0, 1,0,32'h100,32'hAAAA5555, 0,0,0, 1,0,0);
        add(0, 1,1,1,0, 32'h100,32'hAAAA5555,5, 1,32'hDEADBEEF, 1,0, 0,0, 0,0,0,0, 1,1,32'h100, 1,32'hDEADBEEF,5);
        // store 0x40, immediate ack; read data must not leak into MEM/WB
        add(0, 0,0,0,1, 32'h40,32'h12345678,0, 0,0,      1,1, 1,0, 1,1,32'h40,32'h12345678, 0,0,0, 1,0,0);
        add(0, 0,0,0,1, 32'h40,32'h12345678,0, 1,32'hFFFFFFFF, 1,0, 0,0, 0,0,0,0, 0,0,32'h40, 1,0,0);
        // misaligned load 0x102, then error must clear
        add(0, 1,1,1,0, 32'h102,0,7, 0,0,                1,0, 0,1, 0,0,0,0, 0,0,32'h102, 0,0,7);
        add(0, 0,0,0,0, 0,0,0, 0,0,                      1,0, 0,0, 0,0,0,0, 0,0,0, 1,0,0);
        // load with no ack: timeout after 4 request cycles
        add(0, 1,1,1,0, 32'h200,0,9, 0,0,                1,1, 1,0, 1,0,32'h200,0, 0,0,0, 1,0,0);
        add(0, 1,1,1,0, 32'h200,0,9, 0,0,                1,1, 1,0, 1,0,32'h200,0, 0,0,0, 1,0,0);
        add(0, 1,1,1,0, 32'h200,0,9, 0,0,                1,1, 1,0, 1,0,32'h200,0, 0,0,0, 1,0,0);
        add(0, 1,1,1,0, 32'h200,0,9, 0,0,                1,1, 1,0, 1,0,32'h200,0, 0,0,0, 1,0,0);
        add(0, 1,1,1,0, 32'h200,0,9, 0,0,                1,0, 0,1, 0,0,0,0, 0,0,0, 1,0,0);
        add(0, 0,0,0,0, 0,0,0, 0,0,                      1,0, 0,0, 0,0,0,0, 0,0,0, 1,0,0);
        // ack on the exact timeout cycle: normal completion
        add(0, 1,1,1,0, 32'h300,0,10, 0,0,               1,1, 1,0, 1,0,32'h300,0, 0,0,0, 1,0,0);
        add(0, 1,1,1,0, 32'h300,0,10, 0,0,               1,1, 1,0, 1,0,32'h300,0, 0,0,0, 1,0,0);
        add(0, 1,1,1,0, 32'h300,0,10, 0,0,               1,1, 1,0, 1,0,32'h300,0, 0,0,0, 1,0,0);
        add(0, 1,1,1,0, 32'h300,0,10, 0,0,               1,1, 1,0, 1,0,32'h300,0, 0,0,0, 1,0,0);
        add(0, 1,1,1,0, 32'h300,0,10, 1,32'hCAFEF00D,    1,0, 0,0, 0,0,0,0, 1,1,32'h300, 1,32'hCAFEF00D,10);
        // back-to-back store issued right after the ack
        add(0, 0,0,0,1, 32'h44,32'h55,0, 0,0,            1,1, 1,0, 1,1,32'h44,32'h55, 0,0,0, 1,0,0);
        // reset while waiting
        add(1, 0,0,0,1, 32'h44,32'h55,0, 0,0,            0,0, 0,0, 1,0,0,0, 0,0,0, 1,0,0);
        // late ack ignored, ALU op flows with no stall
        add(0, 1,0,0,0, 32'h7,0,2, 1,32'h99,             1,0, 0,0, 0,0,0,0, 1,0,32'h7, 1,0,2);
        // read+write together behaves as a write
        add(0, 0,0,1,1, 32'h80,32'h77,0, 0,0,            1,1, 1,0, 1,1,32'h80,32'h77, 0,0,0, 1,0,0);
        add(0, 0,0,1,1, 32'h80,32'h77,0, 1,32'h1234,     1,0, 0,0, 0,0,0,0, 0,0,32'h80, 1,0,0);
        // misaligned store
        add(0, 0,0,0,1, 32'h41,32'h1,0, 0,0,             1,0, 0,1, 0,0,0,0, 0,0,32'h41, 0,0,0);
        add(0, 0,0,0,0, 0,0,0, 0,0,                      1,0, 0,0, 0,0,0,0, 0,0,0, 1,0,0);

        nop();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            v = vecs[i];
            drive(v);
            #1;
            if (v.cs) chk("stall", i, 32'(stall_o), 32'(v.es));
            exp_q.push_back(v);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk("req", i, 32'(mem_req_o), 32'(e.er));
            chk("err", i, 32'(err_o), 32'(e.ee));
            if (e.cp) begin
                chk("we", i, 32'(mem_we_o), 32'(e.ew));
                chk("addr", i, mem_addr_o, e.ea);
                chk("wdata", i, mem_wdata_o, e.ewd);
            end
            chk("regwrite", i, 32'(RegWrite_o), 32'(e.erw));
            chk("memtoreg", i, 32'(MemtoReg_o), 32'(e.em2r));
            chk("aluresult", i, ALUResult_o, e.ealu);
            if (e.crd) chk("readdata", i, ReadData_o, e.erdata);
            chk("rdaddr", i, 32'(RDaddr_o), 32'(e.erd));
        end
        chk("sb_empty", -1, 32'(exp_q.size()), 32'd0);

        // Timeout measured by counting cycles over a bounded window.
        n_req = 0; n_stall = 0; n_err = 0; released = 1'b0;
        @(negedge clk);
        nop();
        RegWrite_i = 1'b1; MemtoReg_i = 1'b1; MemRead_i = 1'b1;
        ALUResult_i = 32'h500; RDaddr_i = 5'd12;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (stall_o)   n_stall++;
            if (mem_req_o) n_req++;
            if (err_o)     n_err++;
            if (c > 0 && !released && !stall_o) begin
                released = 1'b1;
                @(posedge clk);
                #1;
                nop();
            end
        end
        chk("to_released", -1, 32'(released), 32'd1);
        chk("to_req_cycles", -1, 32'(n_req), 32'd4);
        chk("to_stall_cycles", -1, 32'(n_stall), 32'd4);
        chk("to_err_pulses", -1, 32'(n_err), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
